// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : iterative radix-2 multiply/divide unit for the M extension
// Revision : 1.0
// ============================================================================
module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             neg_a;
   logic             neg_b;
   // Multiply: {acc_hi, acc_lo} is the product. Divide: acc_hi = remainder, acc_lo = quotient.
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic             a_signed;
   logic             b_signed;
   logic             neg_a_in;
   logic             neg_b_in;
   logic [WIDTH-1:0] mag_a_in;
   logic [WIDTH-1:0] mag_b_in;
   logic             b_zero;
   logic             sdiv_ovf;
   logic             special;
   logic [WIDTH-1:0] special_res;

   always_comb begin
      a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      neg_a_in = a_signed & A[WIDTH-1];
      neg_b_in = b_signed & B[WIDTH-1];
      mag_a_in = neg_a_in ? -A : A;
      mag_b_in = neg_b_in ? -B : B;
      b_zero   = (B == '0);
      sdiv_ovf = b_signed && op[2] && (A == MIN_NEG) && (B == '1);
      special  = op[2] && (b_zero || sdiv_ovf);
      // op[1] separates remainder ops from quotient ops within the divide group
      if (b_zero)
         special_res = op[1] ? A : '1;
      else
         special_res = op[1] ? '0 : A;
   end

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mag_b});
      div_diff  = div_shift[WIDTH-1:0] - mag_b;
   end

   logic             sign_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] fix_res;

   always_comb begin
      sign_diff = neg_a ^ neg_b;
      prod_fix  = sign_diff ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo_fix   = sign_diff ? -acc_lo : acc_lo;
      rem_fix   = neg_a ? -acc_hi : acc_hi;
      case (op_q)
         OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              fix_res = quo_fix;
         OP_REM, OP_REMU:              fix_res = rem_fix;
         default:                      fix_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_q   <= op;
                  mag_a  <= mag_a_in;
                  mag_b  <= mag_b_in;
                  neg_a  <= neg_a_in;
                  neg_b  <= neg_b_in;
                  cnt    <= '0;
                  acc_hi <= '0;
                  acc_lo <= op[2] ? mag_a_in : mag_b_in;
                  if (special) begin
                     result <= special_res;
                     state  <= ST_DONE;
                  end else begin
                     state  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else begin
                  if (op_q[2]) begin
                     acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                  end else begin
                     acc_hi <= mul_sum[WIDTH:1];
                     acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_CNT)
                     state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else begin
                  result <= fix_res;
                  state  <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_CALC) || (state == ST_FIX);
   assign done = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// tb_mdu_iter : self-checking bench for mdu_iter against a 64-bit arithmetic model
// Revision    : 1.0
// ============================================================================
module tb_mdu_iter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .A      (a),
      .B      (b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      longint     sx = longint'($signed(x));
      longint     sy = longint'($signed(y));
      longint     ux = longint'({32'd0, x});
      longint     uy = longint'({32'd0, y});
      logic [63:0] p;
      bit         ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         3'd0: p = 64'(ux * uy);
         3'd1: p = 64'(sx * sy) >> 32;
         3'd2: p = 64'(sx * uy) >> 32;
         3'd3: p = 64'(ux * uy) >> 32;
         3'd4: p = (y == 0) ? 64'hFFFF_FFFF : ovf ? {32'd0, x} : 64'(sx / sy);
         3'd5: p = (y == 0) ? 64'hFFFF_FFFF : 64'(ux / uy);
         3'd6: p = (y == 0) ? {32'd0, x} : ovf ? 64'd0 : 64'(sx % sy);
         default: p = (y == 0) ? {32'd0, x} : 64'(ux % uy);
      endcase
      return p[31:0];
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      bit ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF) && (o == 3'd4 || o == 3'd6);
      return (o >= 3'd4 && (y == 0 || ovf)) ? 1 : W + 2;
   endfunction

   // Drives one start pulse; returns at the falling edge of the first cycle after acceptance.
   task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
   endtask

   // Returns done latency in cycles (-1 on timeout), busy-high cycle count and result at done.
   task automatic wait_done(output int lat, output int bcnt, output logic [W-1:0] res);
      lat = -1; bcnt = 0; res = 'x;
      for (int i = 1; i <= 40; i++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = i; res = result;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      logic [2:0]   t_op [13] = '{3'd0, 3'd3, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
      logic [W-1:0] t_a [13] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                 32'h80000000, 32'h80000000};
      logic [W-1:0] t_b [13] = '{32'd6, 32'd6, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [W-1:0] t_r [13] = '{32'd42, 32'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF,
                                 32'd5, 32'h80000000, 32'd0};
      int           lat, bcnt, el;
      logic [W-1:0] res;
      for (int i = 0; i < 13; i++) begin
         el = exp_lat(t_op[i], t_a[i], t_b[i]);
         start_op(t_op[i], t_a[i], t_b[i]);
         wait_done(lat, bcnt, res);
         checks++; if (res !== t_r[i]) begin
            errors++; $display("FAIL dir_result[%0d] op=%0d: got %h expected %h", i, t_op[i], res, t_r[i]);
         end
         checks++; if (lat !== el) begin
            errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el);
         end
         checks++; if (bcnt !== el - 1) begin
            errors++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bcnt, el - 1);
         end
         @(negedge clk);
         checks++; if (result !== t_r[i] || done !== 1'b0) begin
            errors++; $display("FAIL dir_hold[%0d]: got %h done=%b expected %h done=0", i, result, done, t_r[i]);
         end
      end
   endtask

   task automatic test_random();
      int           lat, bcnt, sel;
      logic [2:0]   o;
      logic [W-1:0] x, y, res, exp;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom);
         x = $urandom; y = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) y = '0;
         else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
         else if (sel == 2) begin x = 32'($urandom_range(0, 300)) - 32'd150; y = 32'($urandom_range(1, 20)); end
         exp = model(o, x, y);
         start_op(o, x, y);
         wait_done(lat, bcnt, res);
         checks++; if (res !== exp) begin
            errors++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", o, x, y, res, exp);
         end
         checks++; if (lat !== exp_lat(o, x, y)) begin
            errors++; $display("FAIL rand_latency op=%0d: got %0d expected %0d", o, lat, exp_lat(o, x, y));
         end
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] prev, res;
      int           seen, lat, bcnt;
      prev = result;
      start_op(3'd4, 32'hFFFF0000, 32'h123);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy: got %b expected 0", busy); end
      seen = 0;
      repeat (40) begin
         if (done) seen = 1;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_calc_no_done: got %0d expected 0", seen); end
      checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_kept: got %h expected %h", result, prev); end
      // flush during the sign-fix cycle
      start_op(3'd0, 32'd9, 32'd9);
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_fix: got done=%b busy=%b expected 0 0", done, busy);
      end
      checks++; if (result !== prev) begin errors++; $display("FAIL flush_fix_result: got %h expected %h", result, prev); end
      // start coinciding with flush is dropped
      @(negedge clk);
      op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL flush_with_start: got busy=%b done=%b expected 0 0", busy, done);
      end
      start_op(3'd0, 32'd3, 32'd5);
      wait_done(lat, bcnt, res);
      checks++; if (res !== 32'd15 || lat !== W + 2) begin
         errors++; $display("FAIL after_flush_op: got %h lat %0d expected %h lat %0d", res, lat, 32'd15, W + 2);
      end
   endtask

   task automatic test_reset_mid();
      int           lat, bcnt;
      logic [W-1:0] res;
      start_op(3'd0, 32'd1000, 32'd77);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         errors++; $display("FAIL reset_mid: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_op(3'd7, 32'd100, 32'd7);
      wait_done(lat, bcnt, res);
      checks++; if (res !== 32'd2 || lat !== W + 2) begin
         errors++; $display("FAIL after_reset_op: got %h lat %0d expected %h lat %0d", res, lat, 32'd2, W + 2);
      end
   endtask

   task automatic test_back_to_back();
      int           lat, bcnt, first_done, second_done;
      logic [W-1:0] res, second_res;
      logic         busy35, busy36;
      // start pulse while busy is ignored
      start_op(3'd0, 32'd11, 32'd13);
      repeat (4) @(negedge clk);
      op = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt, res);
      checks++; if (res !== 32'd143) begin errors++; $display("FAIL ignored_start_result: got %h expected %h", res, 32'd143); end
      checks++; if (lat !== W + 2 - 5) begin errors++; $display("FAIL ignored_start_latency: got %0d expected %0d", lat, W - 3); end
      // next start issued in the cycle right after done
      start_op(3'd5, 32'd100, 32'd7);
      wait_done(lat, bcnt, res);
      checks++; if (res !== 32'd14 || lat !== W + 2) begin
         errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat %0d", res, lat, 32'd14, W + 2);
      end
      // start held high through DONE is only accepted once back in IDLE
      @(negedge clk);
      op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
      first_done = -1; second_done = -1; busy35 = 1'bx; busy36 = 1'bx; second_res = 'x;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done && first_done < 0) first_done = c;
         else if (done && second_done < 0) begin second_done = c; second_res = result; end
         if (c == 35) busy35 = busy;
         if (c == 36) busy36 = busy;
         if (c == 37) start = 1'b0;
      end
      checks++; if (first_done !== W + 2) begin errors++; $display("FAIL held_first_done: got %0d expected %0d", first_done, W + 2); end
      checks++; if (busy35 !== 1'b0 || busy36 !== 1'b1) begin
         errors++; $display("FAIL held_busy: got %b%b expected 01", busy35, busy36);
      end
      checks++; if (second_done !== 2 * W + 5) begin errors++; $display("FAIL held_second_done: got %0d expected %0d", second_done, 2 * W + 5); end
      checks++; if (second_res !== 32'd81) begin errors++; $display("FAIL held_result: got %h expected %h", second_res, 32'd81); end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
